// File: rtl/deserial.sv
// deserial: LSB-first strobed serial-to-parallel converter with word resync
// and a first-word-fall-through output FIFO with a sticky overflow flag.
module deserial #(
    parameter int p_width = 8,
    parameter int p_depth = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_val,
    input  logic                         i_stp,
    input  logic                         i_syn,
    input  logic                         i_rdy,
    output logic [p_width-1:0]           o_val,
    output logic                         o_vld,
    output logic [$clog2(p_depth+1)-1:0] o_cnt,
    output logic                         o_ovf
);
    localparam int l_bw = $clog2(p_width);
    localparam int l_aw = $clog2(p_depth);
    localparam int l_cw = $clog2(p_depth + 1);
    localparam logic [l_bw-1:0] l_last = l_bw'(p_width - 1);
    localparam logic [l_cw-1:0] l_full = l_cw'(p_depth);

    logic [p_width-1:0] l_shf, l_word;
    logic [p_width-1:0] l_mem [p_depth];
    logic [l_bw-1:0]    l_bit, l_bit_nx;
    logic [l_aw-1:0]    l_rp, l_wp;
    logic [l_cw-1:0]    l_cnt_nx;
    logic               l_done, l_pop, l_acc;

    always_comb begin
        l_word   = {i_val, l_shf[p_width-1:1]};
        l_done   = i_stp && !i_syn && l_bit == l_last;
        l_pop    = o_vld && i_rdy;
        l_acc    = l_done && (o_cnt != l_full || l_pop);
        l_bit_nx = i_syn ? (i_stp ? l_bw'(1) : '0)
                 : i_stp ? (l_bit == l_last ? '0 : l_bit + 1'b1) : l_bit;
        l_cnt_nx = o_cnt + l_cw'(l_acc) - l_cw'(l_pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            l_shf <= '0;
            l_bit <= '0;
            l_rp  <= '0;
            l_wp  <= '0;
            o_cnt <= '0;
            o_vld <= 1'b0;
            o_ovf <= 1'b0;
        end else begin
            if (i_stp) l_shf <= l_word;
            l_bit <= l_bit_nx;
            if (l_acc) l_wp <= l_wp + 1'b1;
            if (l_pop) l_rp <= l_rp + 1'b1;
            o_cnt <= l_cnt_nx;
            o_vld <= l_cnt_nx != '0;
            if (l_done && !l_acc) o_ovf <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; o_val is masked by o_vld instead.
    always_ff @(posedge i_clk) begin
        if (!i_rst && l_acc) l_mem[l_wp] <= l_word;
    end

    assign o_val = o_vld ? l_mem[l_rp] : '0;
endmodule

// File: tb/tb_deserial.sv
// tb_deserial: directed table-driven checks plus hand-written multi-cycle sequences.
module tb_deserial;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_val = 1'b0;
    logic       i_stp = 1'b0;
    logic       i_syn = 1'b0;
    logic       i_rdy = 1'b0;
    logic [7:0] o_val;
    logic       o_vld;
    logic [2:0] o_cnt;
    logic       o_ovf;

    int checks = 0;
    int errors = 0;

    deserial #(.p_width(8), .p_depth(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .i_stp(i_stp),
        .i_syn(i_syn), .i_rdy(i_rdy), .o_val(o_val), .o_vld(o_vld),
        .o_cnt(o_cnt), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] w;
        int         gap;
        logic [7:0] exp_val;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic send_bit(input logic b);
        i_stp = 1'b1;
        i_val = b;
        step();
        i_stp = 1'b0;
        i_val = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap, input logic rdy_last,
                             output logic early);
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            early = early | o_vld;
            if (i == 7) i_rdy = rdy_last;
            send_bit(w[i]);
            if (i < 7) repeat (gap) step();
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        logic early;
        vecs[0] = '{8'hA5, 0, 8'hA5};
        vecs[1] = '{8'hA5, 3, 8'hA5};
        vecs[2] = '{8'hFF, 0, 8'hFF};
        vecs[3] = '{8'h00, 1, 8'h00};
        vecs[4] = '{8'h81, 2, 8'h81};

        step();
        step();
        i_rst = 1'b0;
        check("rst_vld", o_vld, 0);
        check("rst_val", o_val, 0);
        check("rst_cnt", o_cnt, 0);
        check("rst_ovf", o_ovf, 0);

        i_rdy = 1'b1;
        foreach (vecs[k]) begin
            send_word(vecs[k].w, vecs[k].gap, 1'b1, early);
            check("tbl_early_vld", early, 0);
            check("tbl_vld", o_vld, 1);
            check("tbl_val", o_val, vecs[k].exp_val);
            check("tbl_cnt", o_cnt, 1);
            step();
            check("tbl_pop_cnt", o_cnt, 0);
            check("tbl_pop_vld", o_vld, 0);
        end

        // Resync with strobe: three stray bits then 0x3C starting on the sync cycle.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        i_syn = 1'b1;
        send_bit(1'b0);
        i_syn = 1'b0;
        for (int i = 1; i < 8; i++) begin
            check("syn_no_stray", o_vld, 0);
            send_bit(8'h3C >> i);
        end
        check("syn_vld", o_vld, 1);
        check("syn_val", o_val, 8'h3C);
        step();
        check("syn_single", o_vld, 0);

        // Resync without strobe discards five partial bits.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        i_syn = 1'b1;
        step();
        i_syn = 1'b0;
        send_word(8'h5A, 0, 1'b1, early);
        check("syn0_early", early, 0);
        check("syn0_val", o_val, 8'h5A);
        step();
        check("syn0_single", o_vld, 0);

        // Overflow: five words into a four-deep FIFO with the consumer stalled.
        i_rdy = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(8'(k), 0, 1'b0, early);
        check("ovf_cnt4", o_cnt, 4);
        check("ovf_pre", o_ovf, 0);
        check("ovf_head", o_val, 8'h01);
        send_word(8'h05, 0, 1'b0, early);
        check("ovf_cnt", o_cnt, 4);
        check("ovf_set", o_ovf, 1);
        repeat (3) step();
        check("ovf_hold_val", o_val, 8'h01);
        i_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("ovf_drain_vld", o_vld, 1);
            check("ovf_drain_val", o_val, 8'(k));
            step();
        end
        check("ovf_empty", o_vld, 0);
        check("ovf_sticky", o_ovf, 1);
        i_rdy = 1'b0;
        do_reset();
        check("ovf_clr", o_ovf, 0);

        // Full FIFO with a pop in the same cycle the fifth word completes.
        for (int k = 1; k <= 4; k++) send_word(8'(k), 0, 1'b0, early);
        send_word(8'h05, 0, 1'b1, early);
        check("fp_cnt", o_cnt, 4);
        check("fp_ovf", o_ovf, 0);
        for (int k = 2; k <= 5; k++) begin
            check("fp_drain_val", o_val, 8'(k));
            step();
        end
        check("fp_empty", o_vld, 0);
        check("fp_cnt0", o_cnt, 0);

        // Reset mid-operation with a strobe in the same cycle.
        i_rdy = 1'b0;
        send_word(8'h11, 0, 1'b0, early);
        send_word(8'h22, 0, 1'b0, early);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("mr_pre_cnt", o_cnt, 2);
        i_rst = 1'b1;
        i_stp = 1'b1;
        i_val = 1'b1;
        step();
        i_rst = 1'b0;
        i_stp = 1'b0;
        check("mr_vld", o_vld, 0);
        check("mr_val", o_val, 0);
        check("mr_cnt", o_cnt, 0);
        check("mr_ovf", o_ovf, 0);
        i_rdy = 1'b1;
        send_word(8'h7E, 0, 1'b1, early);
        check("mr_early", early, 0);
        check("mr_word", o_val, 8'h7E);
        check("mr_word_cnt", o_cnt, 1);
        step();
        check("mr_single", o_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/deserial.md
# deserial

Serial-to-parallel converter for the encode path, placed directly downstream of the `serial` parallel-to-serial stage.
- Collects a strobed, LSB-first bit stream into `p_width`-bit words.
- Supports resynchronisation to a word boundary.
- Buffers completed words in a small first-word-fall-through FIFO with a valid/ready output handshake and a sticky overflow flag.

## Interface
- `p_width`, default 8: word width in bits; legal range ≥ 2.
- `p_depth`, default 4: output FIFO depth in words; must be a power of two, ≥ 2.

- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_val`, in, 1: serial data bit; sampled only when `i_stp`=1.
- `i_stp`, in, 1: bit strobe; one data bit per cycle in which it is high.
- `i_syn`, in, 1: word-boundary sync; discards the partial word.
- `i_rdy`, in, 1: consumer ready; a pop occurs when `o_vld` & `i_rdy`.
- `o_val`, out, `p_width`: head-of-FIFO word; forced to 0 when `o_vld`=0.
- `o_vld`, out, 1: FIFO non-empty.
- `o_cnt`, out, `$clog2(p_depth+1)`: FIFO occupancy, 0..`p_depth`.
- `o_ovf`, out, 1: sticky; set when a completed word is dropped; cleared only by reset.

## Operation
**Shifter**
- `l_shf[p_width-1:0]` with bit counter `l_bit` (0..`p_width-1`).
- On `i_stp`: `l_shf` <= {`i_val`, `l_shf[p_width-1:1]`}, so the first received bit ends in bit 0.
- On `i_stp`, `l_bit` increments and wraps from `p_width-1` to 0.

**Word complete**
- Condition: `i_stp`=1 and `l_bit`=`p_width-1` (with no `i_syn`).
- The completed word is {`i_val`, `l_shf[p_width-1:1]`}; it is the push candidate that cycle.

**Sync (`i_syn`=1)**
- `i_syn` & `i_stp`: the current bit becomes bit 0 of a new word; `l_bit` <= 1; `l_shf` shifts as normal. No word completes this cycle, even if `l_bit` was `p_width-1`.
- `i_syn` & !`i_stp`: `l_bit` <= 0; partial word discarded; `l_shf` unchanged (don't care).

**FIFO**
- Storage: `p_depth` × `p_width` memory with read/write pointers of `$clog2(p_depth)` bits, wrapping naturally.
- Push is accepted when `o_cnt` < `p_depth`, or when a pop occurs in the same cycle.
- If a push is refused: the word is dropped, `o_ovf` <= 1, and FIFO contents are unchanged.
- Pop: read pointer advances; `o_val` shows the next entry combinationally from memory.
- Simultaneous push and pop: `o_cnt` unchanged; both pointers advance.
- Pop attempted while empty: impossible, because `o_vld`=0.

**Reset**
- `l_shf`=0, `l_bit`=0, pointers=0, `o_cnt`=0, `o_vld`=0, `o_val`=0, `o_ovf`=0. Memory is not reset.
- Reset mid-word discards the partial word and all buffered words.
- Reset has priority over `i_stp`, `i_syn` and `i_rdy` in the same cycle.

## Timing
- Latency: last bit strobed at edge N → `o_vld`=1 and `o_val` valid in the cycle following edge N (one-cycle latency).
- `o_val` is stable while `o_vld`=1 and `i_rdy`=0; the consumer may hold `i_rdy` low indefinitely.
- Back-to-back strobes (one per cycle) with `i_rdy`=1 sustain 1 word per `p_width` cycles with no loss.
- `i_stp` gaps of any length are allowed mid-word; partial state is held.
- Overflow is flagged in the cycle following the dropped push edge.
- All outputs are registered except `o_val`, which is a combinational memory read at the registered read pointer.

## Test plan
- Word assembly: strobe bits 1,0,1,0,0,1,0,1 (LSB first) with `i_rdy`=1 → `o_val`=8'hA5 and `o_vld`=1 one cycle after the 8th strobe; `o_cnt` 1 → 0 after the pop.
- Strobe gaps: same 0xA5 stream with 3 idle cycles between each bit → identical result; `o_vld` stays 0 until the 8th strobe.
- Resync: send 3 bits, then assert `i_syn`+`i_stp` with the first bit of 0x3C and continue → only 0x3C emerges; no word from the 3 stray bits.
- Overflow: `i_rdy`=0, push 5 words 0x01..0x05 with `p_depth`=4 → `o_cnt`=4, `o_ovf`=1 after the 5th, then draining yields 0x01..0x04 only.
- Full with simultaneous pop: FIFO full, assert `i_rdy` in the cycle a 5th word completes → no overflow; `o_cnt` stays 4; order 0x01..0x05 preserved.
- Reset mid-operation: 2 words buffered plus 5 bits partial, pulse `i_rst` → all outputs 0; next 8 strobed bits of 0x7E produce exactly one word, 0x7E.
